// File: rtl/mult_pkg.sv
// Shared widths, counter sizing and controller state encoding for the
// shift-and-add multiplier.
package mult_pkg;
  localparam int OPW   = 4;
  localparam int PW    = 8;
  localparam int NITER = 4;
  localparam int CNTW  = $clog2(NITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shift_add_multiplier_adder_4bit.sv
// 4-bit ripple-carry adder built from single-bit full adders; this is the
// only arithmetic used by the multiplier datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_4bit
  import mult_pkg::*;
(
  input  logic           cin,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [OPW-1:0] sum,
  output logic           cout
);
  logic [OPW:0] carry;

  assign carry[0] = cin;
  assign cout     = carry[OPW];

  for (genvar i = 0; i < OPW; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-and-add multiplier reusing one ripple adder.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip RUN and finish in one cycle.
module shift_add_multiplier
  import mult_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [PW-1:0]  product
);
  // Handshake: start is accepted only in IDLE (busy=0); while busy=1 start and
  // operands are ignored; done is a one-cycle pulse with product valid, and
  // product holds until the next completion.
  state_t          state;
  logic [OPW-1:0]  mcand, acc, mq;
  logic [CNTW-1:0] cnt;
  logic [OPW-1:0]  addend, sum;
  logic            cout;
  logic [CNTW-1:0] cnt_next;

  assign addend   = mq[0] ? mcand : '0;
  assign cnt_next = {cnt[1] ^ cnt[0], ~cnt[0]};

  adder_4bit u_adder (
    .cin  (1'b0),
    .a    (acc),
    .b    (addend),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            mq    <= b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef MULT_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              product <= '0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          // {acc, mq} <= {cout, sum, mq[3:1]}: shift the partial sum right into mq
          acc <= {cout, sum[OPW-1:1]};
          mq  <= {sum[0], mq[OPW-1:1]};
          cnt <= cnt_next;
          if (cnt == CNTW'(NITER - 1)) begin
            product <= {cout, sum, mq[OPW-1:1]};
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: scoreboard of expected
// products and completion cycles, plus per-cycle busy and held-product checks.
module tb_shift_add_multiplier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done;
  logic [7:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];
  bit         busy_map[int];
  logic [7:0] model_prod = '0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst_n) model_prod = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int latency(input int x, input int y);
`ifdef MULT_ZERO_BYPASS_EN
    if (x == 0 || y == 0) return 1;
`endif
    return 5;
  endfunction

  function automatic void expect_op(input int x, input int y, input int issue);
    int lat = latency(x, y);
    exp_q.push_back(8'(x * y));
    exp_cyc_q.push_back(issue + lat);
    for (int i = 1; i <= lat; i++) busy_map[issue + i] = 1'b1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", busy, 0);
  endtask

  // driver: one start pulse, sampled by the next rising edge
  task automatic do_op(input int x, input int y, input bit push);
    wait_idle();
    a = 4'(x);
    b = 4'(y);
    start = 1'b1;
    if (push) expect_op(x, y, cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", busy, busy_map.exists(cyc) ? 1 : 0);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [7:0] ep;
          int         ec;
          ep = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("done_cycle", cyc, ec);
          check("product_at_done", product, ep);
          model_prod = ep;
        end
      end else begin
        check("product_held", product, model_prod);
      end
    end
  end

  initial begin
    int c, n;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // directed operands
    do_op(15, 15, 1);
    do_op(7, 1, 1);
    do_op(1, 8, 1);
    do_op(0, 9, 1);
    do_op(3, 3, 1);

    // second start during RUN must be ignored
    do_op(3, 5, 1);
    @(negedge clk);
    a = 4'd14; b = 4'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // reset in cycle 3 aborts 12*12
    do_op(12, 12, 0);
    for (int i = 1; i <= 5; i++) busy_map[cyc - 1 + i] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    c = cyc;
    for (int i = 1; i <= 8; i++) if (busy_map.exists(c + i)) busy_map.delete(c + i);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_product", product, 0);
    rst_n = 1'b1;
    do_op(12, 12, 1);

    // start held high: back-to-back every 6 cycles
    wait_idle();
    a = 4'd9; b = 4'd11; start = 1'b1;
    c = cyc;
    for (int k = 0; k < 3; k++) expect_op(9, 11, c + 6 * k);
    repeat (13) @(negedge clk);
    start = 1'b0;

    // randomized operands, zeros included
    for (int i = 0; i < 40; i++) begin
      int x, y;
      x = (i % 7 == 0) ? 0 : int'($urandom_range(0, 15));
      y = (i % 11 == 3) ? 0 : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(x, y, 1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Sequential 4x4 unsigned multiplier that reuses a single 4-bit ripple adder over four clock cycles. It performs shift-and-add and produces an 8-bit product, the same result width as the existing adder blocks. It sits between operand sources and the display/result path and owns the adder's sequencing: operand selection, carry capture, shifting and iteration count.

## Interface
- No parameters; widths are fixed constants in the package (operand 4, product 8, iteration count 4).
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  4  multiplicand, unsigned
- b  input  4  multiplier, unsigned
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, product valid
- product  output  8  registered a*b, held until next completion

## Operation
- Registers: mcand[3:0], acc[3:0], mq[3:0], cnt[1:0], state, product[7:0].
- States: IDLE, RUN, DONE.
- IDLE: if start=1, latch mcand=a, mq=b, acc=0, cnt=0, then go to RUN; otherwise hold.
- RUN, each cycle:
  - Adder inputs are acc and (mq[0] ? mcand : 0), with carry-in 0.
  - Update {acc, mq} <= {cout, sum, mq[3:1]}, a 9-bit right shift keeping the low 8 bits.
  - cnt increments; on cnt==3, write product <= the updated {acc, mq} and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Arithmetic: the result is always exact (max 15*15=225 fits in 8 bits), so no overflow output exists. The adder carry-out is the only carry state and is consumed in the same cycle.
- Busy handling: start while busy is ignored, with no queueing, and operand changes during RUN have no effect. start held high continuously yields back-to-back operations, one per 6 cycles.
- Reset:
  - rst_n=0 at any clock edge forces IDLE, busy=0, done=0, product=0, acc=0, mq=0, mcand=0, cnt=0.
  - A reset mid-operation aborts the operation with no done pulse.
  - Reset has priority over start.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1-4: RUN, busy=1.
- Cycle 5: DONE, done=1, busy=1, new product visible.
- Cycle 6: IDLE, busy=0; the earliest next start is sampled here.
- Start-to-done latency is 5 cycles; throughput is one multiply per 6 cycles.
- Outputs are fully registered, with no combinational path from inputs to outputs.
- After reset: busy=0, done=0, product=8'h00.

## Configuration
- Macro: MULT_ZERO_BYPASS_EN.
- Defined: if start is accepted with a==0 or b==0, go directly IDLE->DONE, writing product=0 at the same edge. done asserts in cycle 1 (latency 1), and RUN is skipped.
- Undefined: every operation takes the full 4 RUN cycles, including zero operands (latency 5).
- Nonzero operands behave identically either way.

## Structure
- Package mult_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - OPW=4, PW=8, NITER=4;
  - the cnt width.
- Sub-module adder_4bit: a 4-bit ripple adder of full_adder instances with cin, a, b, sum[3:0] and cout. It is instantiated once; the controller contains no '+' operator.

## Test plan
- a=15, b=15, start pulse -> done in cycle 5, product=8'hE1 (225), busy high cycles 1-5.
- a=7, b=1 -> product=8'h07. a=1, b=8 -> product=8'h08. Both with done at cycle 5.
- a=0, b=9 -> product=0. Done at cycle 5 without MULT_ZERO_BYPASS_EN, at cycle 1 with it. A follow-up 3*3 gives latency 5 in both builds.
- Start a=3, b=5, then change a/b and pulse start in cycle 2 -> the second start is ignored, product=8'h0F, exactly one done.
- Start a=12, b=12, then rst_n=0 in cycle 3 -> no done pulse, product=0, busy=0 next cycle. After release, 12*12 gives 8'h90.
- start held high with a=9, b=11 -> done pulses at cycles 5, 11, 17, product=8'h63 each time.
